// File: rtl/expr_pkg.sv
// ==========================================================================
// expr_pkg : shared types and ASCII constants for expr_eval  (rev 1.0)
// ==========================================================================
`default_nettype none

package expr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NUM  = 2'd1,
    OP   = 2'd2,
    ERR  = 2'd3
  } state_t;

  localparam logic [7:0] ASCII_0   = 8'h30;
  localparam logic [7:0] ASCII_9   = 8'h39;
  localparam logic [7:0] ASCII_ADD = 8'h2B;
  localparam logic [7:0] ASCII_SUB = 8'h2D;
  localparam logic [7:0] ASCII_MUL = 8'h2A;

  typedef enum logic [2:0] {
    CC_DIGIT = 3'd0,
    CC_ADD   = 3'd1,
    CC_SUB   = 3'd2,
    CC_MUL   = 3'd3,
    CC_OTHER = 3'd4
  } cclass_t;

endpackage

`default_nettype wire

// File: rtl/expr_char_decode.sv
// ==========================================================================
// expr_char_decode : ASCII character classifier and digit extract (rev 1.0)
// ==========================================================================
`default_nettype none

module expr_char_decode
  import expr_pkg::*;
#(
  parameter int ALLOW_SUB = 1
) (
  input  logic [7:0] in,
  output cclass_t    cls,
  output logic [3:0] digit
);

  always_comb begin
    cls = CC_OTHER;
    if ((in >= ASCII_0) && (in <= ASCII_9)) begin
      cls = CC_DIGIT;
    end else if (in == ASCII_ADD) begin
      cls = CC_ADD;
    end else if (in == ASCII_MUL) begin
      cls = CC_MUL;
    end else if ((ALLOW_SUB != 0) && (in == ASCII_SUB)) begin
      cls = CC_SUB;
    end
  end

  // ASCII digits 0x30..0x39 carry their value in the low nibble
  assign digit = in[3:0];

endmodule

`default_nettype wire

// File: rtl/expr_eval.sv
// ==========================================================================
// expr_eval : streaming ASCII +,-,* expression recogniser/evaluator (rev 1.0)
// ==========================================================================
`default_nettype none

module expr_eval
  import expr_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MAX_DIGITS = 3,
  parameter int ALLOW_SUB  = 1
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [7:0]       in,
  output logic             out,
  output logic             err,
  output logic [WIDTH-1:0] result
);

  localparam int DCNT_W = $clog2(MAX_DIGITS + 1);

  state_t             state, state_d;
  logic [WIDTH-1:0]   acc, acc_d;
  logic [WIDTH-1:0]   term, term_d;
  logic [WIDTH-1:0]   num, num_d;
  logic [WIDTH-1:0]   result_d;
  logic [DCNT_W-1:0]  dcnt, dcnt_d;

  cclass_t            cls;
  logic [3:0]         digit;
  logic [WIDTH-1:0]   num_x10;
  logic [WIDTH-1:0]   num_dig;
  logic [WIDTH-1:0]   mul_b;
  logic [WIDTH-1:0]   prod;
  logic               digit_room;

  expr_char_decode #(
    .ALLOW_SUB (ALLOW_SUB)
  ) u_decode (
    .in    (in),
    .cls   (cls),
    .digit (digit)
  );

  assign num_x10    = (num << 3) + (num << 1);
  assign num_dig    = num_x10 + WIDTH'(digit);
  // One shared multiplier: term*(new num) for digits, term*num for operators
  assign mul_b      = (cls == CC_DIGIT) ? num_dig : num;
  assign prod       = term * mul_b;
  assign digit_room = (dcnt < DCNT_W'(MAX_DIGITS));

  always_comb begin
    state_d  = state;
    acc_d    = acc;
    term_d   = term;
    num_d    = num;
    dcnt_d   = dcnt;
    result_d = result;
    if (in_valid) begin
      unique case (state)
        IDLE, OP: begin
          if (cls == CC_DIGIT) begin
            state_d  = NUM;
            num_d    = num_dig;
            dcnt_d   = dcnt + 1'b1;
            result_d = acc + prod;
          end else begin
            state_d  = ERR;
          end
        end
        NUM: begin
          case (cls)
            CC_DIGIT: begin
              if (digit_room) begin
                num_d    = num_dig;
                dcnt_d   = dcnt + 1'b1;
                result_d = acc + prod;
              end else begin
                state_d  = ERR;
              end
            end
            CC_MUL: begin
              state_d = OP;
              term_d  = prod;
              num_d   = '0;
              dcnt_d  = '0;
            end
            CC_ADD, CC_SUB: begin
              state_d = OP;
              acc_d   = acc + prod;
              term_d  = (cls == CC_SUB) ? '1 : WIDTH'(1);
              num_d   = '0;
              dcnt_d  = '0;
            end
            default: state_d = ERR;
          endcase
        end
        ERR: state_d = ERR;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state  <= IDLE;
      acc    <= '0;
      term   <= WIDTH'(1);
      num    <= '0;
      dcnt   <= '0;
      result <= '0;
    end else if (clr) begin
      state  <= IDLE;
      acc    <= '0;
      term   <= WIDTH'(1);
      num    <= '0;
      dcnt   <= '0;
      result <= '0;
    end else begin
      state  <= state_d;
      acc    <= acc_d;
      term   <= term_d;
      num    <= num_d;
      dcnt   <= dcnt_d;
      result <= result_d;
    end
  end

  assign out = (state == NUM);
  assign err = (state == ERR);

endmodule

`default_nettype wire

// File: doc/expr_eval.md
# expr_eval

Streaming ASCII arithmetic-expression recogniser and evaluator, the parametrised successor to the single-digit `+`/`*` string checker. It consumes one character per accepted beat and tracks whether the stream so far is a well-formed expression. The grammar is operand (op operand)*, with multi-digit operands and optional `-`. It maintains the running value with `*` binding tighter than `+`/`-`. It sits behind the character source (UART/console front end) and drives the result and status flags to the display/compare logic.

## Interface
- WIDTH, 32: result width; all arithmetic is two's complement modulo 2^WIDTH.
- MAX_DIGITS, 3: maximum digits per operand, ≥1.
- ALLOW_SUB, 1: when 1, `-` (0x2D) is an operator; when 0, it is an illegal character.

- clk  in  1  clock; all state changes on the rising edge.
- clr_n  in  1  reset, asynchronous, active-low.
- clr  in  1  synchronous restart; has priority over in_valid.
- in_valid  in  1  `in` carries a character this cycle.
- in  in  8  ASCII character.
- out  out  1  stream so far is a complete valid expression (ends in a digit, no error).
- err  out  1  sticky syntax error.
- result  out  WIDTH  value of the expression up to the last accepted digit.

## Operation
- States:
  - IDLE: expect first digit.
  - NUM: inside an operand.
  - OP: operator seen, expect digit.
  - ERR: absorbing.
- Character classes:
  - digit: 0x30–0x39.
  - op: `+` (0x2B), `*` (0x2A), and `-` only if ALLOW_SUB.
  - other: everything else.
- Transitions, on accepted beat (in_valid=1, clr=0):
  - IDLE: digit→NUM; else→ERR.
  - NUM: digit→NUM if dcnt<MAX_DIGITS, else ERR; op→OP; other→ERR.
  - OP: digit→NUM; else→ERR.
  - ERR: stays in ERR.
- Internal registers:
  - acc: sum of closed terms.
  - term: signed product of closed factors in the current term.
  - num: current operand.
  - dcnt: digit count, clog2(MAX_DIGITS+1) bits.
- Digit d: num←num*10+d; dcnt←dcnt+1; result←acc+term*(num*10+d).
- Operator `*`: term←term*num; num←0; dcnt←0.
- Operator `+`: acc←acc+term*num; term←1; num←0; dcnt←0.
- Operator `-`: acc←acc+term*num; term←−1; num←0; dcnt←0.
- All products and sums are truncated to WIDTH bits. Wrap is not an error.
- Leading zeros are legal and count toward MAX_DIGITS.
- out = (state==NUM). err = (state==ERR).
- On entry to ERR, acc/term/num/result freeze.
- clr=1 returns to IDLE with acc=0, term=1, num=0, dcnt=0, result=0. A beat presented in the same cycle is dropped.
- in_valid=0: nothing changes.

## Timing
- Reset (clr_n=0, asynchronous): state=IDLE, out=0, err=0, result=0, acc=0, term=1, num=0, dcnt=0.
- Release of clr_n is assumed synchronous to clk upstream.
- All outputs are registered. A beat accepted at edge N is reflected on out/err/result after edge N.
- No backpressure: one character per cycle at full rate.
- clr_n asserted mid-expression: everything clears immediately. The first beat after release is treated as the start of a new expression.

## Structure
- Package `expr_pkg`:
  - state enum {IDLE, NUM, OP, ERR};
  - ASCII constants for `0`, `9`, `+`, `-`, `*`;
  - char-class enum {CC_DIGIT, CC_ADD, CC_SUB, CC_MUL, CC_OTHER}.
- Sub-module `expr_char_decode`: combinational; inputs `in` and ALLOW_SUB; outputs class and 4-bit digit value.
- Top: FSM, datapath registers, WIDTH-bit multiplier term*num and ×10 (shift-add).

## Test plan
- "1+2*3" at full rate, default params → after last beat out=1, err=0, result=7. After each beat, out follows 1,0,1,0,1.
- "12*3-4*5" → result=16. Then "2-5" after clr → result=0xFFFFFFFD, out=1.
- WIDTH=8, "99*99" → result=73 (9801 mod 256), err=0.
- "1234" with MAX_DIGITS=3 → err=1 after the 4th beat, result holds 123. "1+2*3**" → err=1 at the second `*`, sticks through 5 further beats. clr=1 → err=0, out=0, result=0.
- ALLOW_SUB=0, "5-1" → err=1 on `-`. A leading `+` → err=1 on the first beat.
- Boundaries:
  - clr=1 together with in_valid=1, in="7" → beat dropped, result=0, out=0.
  - clr_n pulsed low between clock edges after "4*" → result=0, IDLE. Then "8" → result=8.
  - in_valid=0 gaps inside "3*4" → result=12, unchanged during gaps.
